// File: rtl/blink_pkg.sv
// Shared timing constants and FSM state type for the blinker / blink_decoder pair.
// Both ends import this package so pulse and gap timing agree.
package blink_pkg;

  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_MIN_PULSE   = 4;
  localparam int unsigned DEF_LONG_THRESH = 1000;
  localparam int unsigned DEF_GAP_THRESH  = 3000;
  localparam int unsigned DEF_SYM_BITS    = 7;

  // Width of the pulse-count field reported with each symbol.
  localparam int unsigned LEN_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/blink_decoder_sync_edge.sv
// sync_edge: two-flop synchronizer for an asynchronous line plus an edge
// register on the synchronized level.
//   clk, rst_n : clock, asynchronous active-low reset
//   blink_in   : asynchronous input line
//   lvl        : synchronized level
//   rise, fall : one-cycle strobes on level changes of lvl
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic blink_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic lvl_q,  lvl_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = blink_in;
    lvl_d  = meta_q;
    prev_d = lvl_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      lvl_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      lvl_q  <= lvl_d;
      prev_q <= prev_d;
    end
  end

  assign lvl  = lvl_q;
  assign rise = lvl_q & ~prev_q;
  assign fall = ~lvl_q & prev_q;

endmodule

// File: rtl/blink_decoder.sv
// blink_decoder: measures high pulses and the gaps after them on a blinking
// input, classifies accepted pulses as short (0) or long (1), gathers them
// into a symbol and presents it with a one-cycle strobe once the line has
// been low for GAP_THRESH cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   blink_in   : asynchronous blink line
//   sym_data   : last completed symbol, newest pulse in bit 0
//   sym_len    : number of pulses in sym_data
//   sym_valid  : one-cycle strobe when sym_data/sym_len/sym_ovf update
//   sym_ovf    : last symbol had more than SYM_BITS pulses
//   last_width : width of the most recent accepted pulse
module blink_decoder
  import blink_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned MIN_PULSE   = DEF_MIN_PULSE,
  parameter int unsigned LONG_THRESH = DEF_LONG_THRESH,
  parameter int unsigned GAP_THRESH  = DEF_GAP_THRESH,
  parameter int unsigned SYM_BITS    = DEF_SYM_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                blink_in,
  output logic [SYM_BITS-1:0] sym_data,
  output logic [LEN_W-1:0]    sym_len,
  output logic                sym_valid,
  output logic                sym_ovf,
  output logic [CNT_W-1:0]    last_width
);

  logic lvl, rise, fall;

  sync_edge u_sync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .blink_in (blink_in),
    .lvl      (lvl),
    .rise     (rise),
    .fall     (fall)
  );

  state_e              state_q,      state_d;
  logic [CNT_W-1:0]    width_q,      width_d;
  logic [CNT_W-1:0]    gap_q,        gap_d;
  logic [SYM_BITS-1:0] shreg_q,      shreg_d;
  logic [LEN_W-1:0]    cnt_q,        cnt_d;
  logic                ovf_q,        ovf_d;
  logic [SYM_BITS-1:0] sym_data_q,   sym_data_d;
  logic [LEN_W-1:0]    sym_len_q,    sym_len_d;
  logic                sym_valid_q,  sym_valid_d;
  logic                sym_ovf_q,    sym_ovf_d;
  logic [CNT_W-1:0]    last_width_q, last_width_d;
  logic                long_bit;

  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    gap_d        = gap_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    sym_data_d   = sym_data_q;
    sym_len_d    = sym_len_q;
    sym_valid_d  = 1'b0;
    sym_ovf_d    = sym_ovf_q;
    last_width_d = last_width_q;
    long_bit     = (width_q >= CNT_W'(LONG_THRESH));

    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          width_d = CNT_W'(1);
        end
      end

      ST_HIGH: begin
        if (fall) begin
          state_d = ST_LOW;
          gap_d   = CNT_W'(1);
          // Pulses below MIN_PULSE are glitches: no shift, no width report.
          if (width_q >= CNT_W'(MIN_PULSE)) begin
            if (cnt_q < LEN_W'(SYM_BITS)) begin
              shreg_d = {shreg_q[SYM_BITS-2:0], long_bit};
              cnt_d   = cnt_q + LEN_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
            last_width_d = width_q;
          end
        end else if (lvl && (width_q != '1)) begin
          width_d = width_q + CNT_W'(1);
        end
      end

      ST_LOW: begin
        // Emit is checked before rise so a rise landing on the closing
        // cycle is swallowed and the FSM waits for the following rise.
        if (gap_q == CNT_W'(GAP_THRESH)) begin
          state_d = ST_IDLE;
          if (cnt_q != '0) begin
            sym_data_d  = shreg_q;
            sym_len_d   = cnt_q;
            sym_ovf_d   = ovf_q;
            sym_valid_d = 1'b1;
          end
          shreg_d = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (rise) begin
          state_d = ST_HIGH;
          width_d = CNT_W'(1);
        end else if (!lvl && (gap_q != '1)) begin
          gap_d = gap_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      width_q      <= '0;
      gap_q        <= '0;
      shreg_q      <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      sym_data_q   <= '0;
      sym_len_q    <= '0;
      sym_valid_q  <= 1'b0;
      sym_ovf_q    <= 1'b0;
      last_width_q <= '0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      gap_q        <= gap_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      sym_data_q   <= sym_data_d;
      sym_len_q    <= sym_len_d;
      sym_valid_q  <= sym_valid_d;
      sym_ovf_q    <= sym_ovf_d;
      last_width_q <= last_width_d;
    end
  end

  assign sym_data   = sym_data_q;
  assign sym_len    = sym_len_q;
  assign sym_valid  = sym_valid_q;
  assign sym_ovf    = sym_ovf_q;
  assign last_width = last_width_q;

endmodule

// File: tb/tb_blink_decoder.sv
// Self-checking bench for blink_decoder: directed scenarios followed by a
// randomized pulse train compared against a pulse-list reference model.
module tb_blink_decoder;

  localparam int unsigned CW = 16;
  localparam int unsigned MP = 4;
  localparam int unsigned LT = 10;
  localparam int unsigned GT = 20;
  localparam int unsigned SB = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          blink_in = 1'b0;
  logic [SB-1:0] sym_data;
  logic [2:0]    sym_len;
  logic          sym_valid;
  logic          sym_ovf;
  logic [CW-1:0] last_width;

  blink_decoder #(
    .CNT_W       (CW),
    .MIN_PULSE   (MP),
    .LONG_THRESH (LT),
    .GAP_THRESH  (GT),
    .SYM_BITS    (SB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .blink_in   (blink_in),
    .sym_data   (sym_data),
    .sym_len    (sym_len),
    .sym_valid  (sym_valid),
    .sym_ovf    (sym_ovf),
    .last_width (last_width)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0]  data;
    logic [2:0]  len;
    logic        ovf;
    logic [15:0] lw;
  } sym_t;

  sym_t obs_q[$];
  sym_t exp_q[$];
  int   valid_cnt  = 0;
  logic prev_valid = 1'b0;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (sym_valid) begin
      sym_t s;
      checks++;
      assert (prev_valid === 1'b0) else begin
        errors++;
        $error("FAIL valid_one_cycle observed=two-cycle strobe expected=single cycle");
      end
      s.data = sym_data;
      s.len  = sym_len;
      s.ovf  = sym_ovf;
      s.lw   = last_width;
      obs_q.push_back(s);
      valid_cnt++;
    end
    prev_valid = sym_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [6:0] d, input logic [2:0] l,
                            input logic o, input logic [15:0] w);
    check({tag, "_data"}, 32'(sym_data), 32'(d));
    check({tag, "_len"},  32'(sym_len),  32'(l));
    check({tag, "_ovf"},  32'(sym_ovf),  32'(o));
    check({tag, "_lw"},   32'(last_width), 32'(w));
  endtask

  // Hold the line at lv for exactly n sampling edges.
  task automatic seg(input logic lv, input int n);
    blink_in = lv;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input int budget, output int k);
    bit seen;
    seen = 0;
    k = 0;
    while (!seen && k < budget) begin
      @(posedge clk);
      #1;
      k++;
      if (sym_valid) seen = 1;
    end
  endtask

  initial begin
    int vc0;
    int k;
    int bits[$];
    int lw_m;
    bit ovf_m;
    bit skip;
    int hi, lo, r, n;
    sym_t e;

    @(posedge clk);
    #1;

    // Reset with line toggling
    for (int i = 0; i < 10; i++) seg(i[0], 1);
    check("rst_valid", 32'(sym_valid), 32'd0);
    check_outs("rst", 7'd0, 3'd0, 1'b0, 16'd0);
    blink_in = 1'b0;
    rst_n = 1'b1;
    vc0 = valid_cnt;
    seg(0, 25);
    check("rst_no_strobe", 32'(valid_cnt - vc0), 32'd0);

    // 5 / 5 / 12 then low: strobe latency and contents
    vc0 = valid_cnt;
    seg(1, 5); seg(0, 5); seg(1, 12);
    blink_in = 1'b0;
    wait_strobe(40, k);
    check("basic_latency", 32'(k), 32'd23);
    check_outs("basic", 7'b0000001, 3'd2, 1'b0, 16'd12);
    seg(0, 30 - k);
    check("basic_count", 32'(valid_cnt - vc0), 32'd1);

    // Glitch inside a symbol
    vc0 = valid_cnt;
    seg(1, 12); seg(0, 5); seg(1, 2); seg(0, 5); seg(1, 5); seg(0, 30);
    check("glitch_count", 32'(valid_cnt - vc0), 32'd1);
    check_outs("glitch", 7'b0000010, 3'd2, 1'b0, 16'd5);

    // Symbol of glitches only
    vc0 = valid_cnt;
    seg(1, 2); seg(0, 5); seg(1, 3); seg(0, 30);
    check("allglitch_count", 32'(valid_cnt - vc0), 32'd0);
    check_outs("allglitch_hold", 7'b0000010, 3'd2, 1'b0, 16'd5);

    // Overflow: eight long pulses
    vc0 = valid_cnt;
    for (int i = 0; i < 8; i++) begin
      seg(1, 12);
      seg(0, (i == 7) ? 30 : 5);
    end
    check("ovf_count", 32'(valid_cnt - vc0), 32'd1);
    check_outs("ovf", 7'b1111111, 3'd7, 1'b1, 16'd12);
    seg(1, 5); seg(0, 30);
    check_outs("after_ovf", 7'b0000000, 3'd1, 1'b0, 16'd5);

    // Gap of 19 keeps the symbol open
    vc0 = valid_cnt;
    seg(1, 12); seg(0, 19); seg(1, 5); seg(0, 30);
    check("gap19_count", 32'(valid_cnt - vc0), 32'd1);
    check_outs("gap19", 7'b0000010, 3'd2, 1'b0, 16'd5);

    // Gap of 20 closes; the coinciding pulse is ignored
    vc0 = valid_cnt;
    seg(1, 12); seg(0, 20); seg(1, 6); seg(0, 30);
    check("gap20_count", 32'(valid_cnt - vc0), 32'd1);
    check_outs("gap20", 7'b0000001, 3'd1, 1'b0, 16'd12);
    vc0 = valid_cnt;
    seg(1, 5); seg(0, 30);
    check("gap20_next_count", 32'(valid_cnt - vc0), 32'd1);
    check_outs("gap20_next", 7'b0000000, 3'd1, 1'b0, 16'd5);

    // Reset during the third pulse
    seg(1, 12); seg(0, 5); seg(1, 12); seg(0, 5);
    seg(1, 4);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(sym_valid), 32'd0);
    check_outs("midrst", 7'd0, 3'd0, 1'b0, 16'd0);
    blink_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vc0 = valid_cnt;
    seg(0, 5); seg(1, 12); seg(0, 30);
    check("postrst_count", 32'(valid_cnt - vc0), 32'd1);
    check_outs("postrst", 7'b0000001, 3'd1, 1'b0, 16'd12);

    // Randomized pulse train against a pulse-list model
    rst_n = 1'b0;
    blink_in = 1'b0;
    #3;
    rst_n = 1'b1;
    seg(0, 5);
    obs_q.delete();
    exp_q.delete();
    bits.delete();
    lw_m = 0;
    ovf_m = 0;
    skip = 0;
    n = 60;
    for (int i = 0; i < n; i++) begin
      hi = $urandom_range(1, 15);
      r  = $urandom_range(0, 9);
      if (i == n - 1)  lo = GT + 5;
      else if (r < 2)  lo = 19;
      else if (r < 4)  lo = 20;
      else if (r < 5)  lo = 21 + $urandom_range(0, 10);
      else             lo = $urandom_range(1, 12);
      seg(1, hi);
      seg(0, lo);
      if (skip) begin
        // Pulse began exactly as the previous symbol closed: not seen.
        skip = 0;
      end else begin
        if (hi >= MP) begin
          lw_m = hi;
          if (bits.size() < SB) bits.push_back((hi >= LT) ? 1 : 0);
          else ovf_m = 1;
        end
        if (lo >= GT) begin
          if (bits.size() > 0) begin
            e.data = '0;
            foreach (bits[j]) e.data = {e.data[5:0], bits[j][0]};
            e.len = 3'(bits.size());
            e.ovf = ovf_m;
            e.lw  = 16'(lw_m);
            exp_q.push_back(e);
          end
          bits.delete();
          ovf_m = 0;
          skip = (lo == GT);
        end
      end
    end
    seg(0, 5);
    check("rand_sym_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("rand%0d_data", i), 32'(obs_q[i].data), 32'(exp_q[i].data));
      check($sformatf("rand%0d_len", i),  32'(obs_q[i].len),  32'(exp_q[i].len));
      check($sformatf("rand%0d_ovf", i),  32'(obs_q[i].ovf),  32'(exp_q[i].ovf));
      check($sformatf("rand%0d_lw", i),   32'(obs_q[i].lw),   32'(exp_q[i].lw));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blink_decoder.md
# blink_decoder

Receive-side counterpart to the on-chip blinker: samples a blinking input pin, measures each high pulse and the gap after it, and sorts pulses into short and long. Pulse bits are gathered into a symbol that closes after a long enough gap, then is presented with a one-cycle valid strobe. It sits behind a dedicated input (`ui_in[0]`) in the top-level wrapper, and its outputs feed `uo_out`. This gives a loopback path for the blinker and a simple pulse-coded input channel.

## Interface
Parameters:
- `CNT_W`, 16: width of the pulse and gap counters; both saturate at all-ones.
- `MIN_PULSE`, 4: high pulses shorter than this many cycles are glitches and are discarded.
- `LONG_THRESH`, 1000: a pulse width of at least this value is long (bit 1); otherwise short (bit 0).
- `GAP_THRESH`, 3000: low time, in cycles, that closes a symbol.
- `SYM_BITS`, 7: maximum number of pulses per symbol.

Ports:
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `blink_in`, input, 1: asynchronous blink line.
- `sym_data`, output, `SYM_BITS`: last completed symbol.
- `sym_len`, output, 3: number of pulses in `sym_data` (0..`SYM_BITS`).
- `sym_valid`, output, 1: one-cycle strobe; `sym_data` and `sym_len` are new.
- `sym_ovf`, output, 1: last completed symbol had more than `SYM_BITS` pulses.
- `last_width`, output, `CNT_W`: width of the most recent accepted pulse.

## Operation
- `blink_in` passes through a 2-flop synchronizer. Rise and fall edges are detected on the synchronized level `lvl`.
- State machine:
  - IDLE: waiting for a rise. A rise moves to HIGH, with `width` loaded to 1.
  - HIGH: `width` increments each cycle while `lvl`=1, saturating at 2^`CNT_W`-1. A fall moves to LOW, with `gap` loaded to 1.
  - LOW: `gap` increments while `lvl`=0. A rise moves to HIGH (`width` := 1). When `gap` reaches `GAP_THRESH`, emit the symbol and go to IDLE.
- Pulse classification happens on the fall (the transition from HIGH to LOW):
  - `width` < `MIN_PULSE`: pulse dropped. No shift, no `last_width` update.
  - Otherwise:
    - Bit = (`width` >= `LONG_THRESH`).
    - If `cnt` < `SYM_BITS`: `shreg` := {`shreg`[SYM_BITS-2:0], bit} and `cnt`++.
    - Else: set internal `ovf`, leave `shreg` unchanged.
    - `last_width` := `width`.
- Bit order: the first pulse lands at bit `cnt`-1 and the newest pulse at bit 0. Unused upper bits are 0.
- Emit (LOW to IDLE):
  - If `cnt` > 0: `sym_data` := `shreg`, `sym_len` := `cnt`, `sym_ovf` := `ovf`, and `sym_valid`=1 for exactly one cycle.
  - Then `shreg`, `cnt`, and `ovf` clear.
  - If `cnt` = 0 (every pulse was a glitch): no strobe, and the outputs hold.
- Stuck-high line: `width` saturates and the FSM stays in HIGH. An eventual fall classifies the pulse as long.
- `sym_data`, `sym_len`, `sym_ovf` and `last_width` hold their values until the next update.

## Timing
- Reset values: all outputs 0, state IDLE, synchronizer flops 0, counters 0.
- `rst_n` going low mid-pulse or mid-symbol aborts immediately, and the partial symbol is lost.
- Latency: an edge on `blink_in` is acted on 3 cycles later (2 synchronizer cycles plus 1 edge-register cycle).
- A `blink_in` high for N whole cycles gives `width` = N.
- `sym_valid` rises in the cycle after `gap` = `GAP_THRESH`, which is `GAP_THRESH`+3 cycles after the falling `blink_in` edge.
- Rise in the same cycle as `gap` = `GAP_THRESH`: emit wins, the FSM enters IDLE, and that rise is ignored. The pulse is then seen from its next rise.
- One symbol at a time. A new symbol cannot complete in fewer than `GAP_THRESH` cycles after the previous `sym_valid`.
- No back-pressure: the consumer must capture on `sym_valid`.

## Structure
- Package `blink_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_HIGH`, `ST_LOW`);
  - default constants for `CNT_W`, `MIN_PULSE`, `LONG_THRESH`, `GAP_THRESH`, `SYM_BITS`, shared with the blinker so both ends agree on timing.
- One sub-module, `sync_edge`: the 2-flop synchronizer plus edge register. It outputs `lvl`, `rise` and `fall`, and has the same clock and reset as the parent.
- The counters, shift register and FSM stay in `blink_decoder`.

## Test plan
Bench parameters: `MIN_PULSE`=4, `LONG_THRESH`=10, `GAP_THRESH`=20.
- Reset with `blink_in` toggling: all outputs read 0 while `rst_n`=0, and there is no `sym_valid` for 25 cycles after release with the line held low.
- Pulses of 5 (high) / 5 (low) / 12 (high), then 30 cycles low: exactly one `sym_valid`, with `sym_data`=7'b0000001, `sym_len`=2, `sym_ovf`=0, `last_width`=12. The strobe lands 23 cycles after the last falling edge.
- Glitch pulses of 2 cycles inside a symbol: dropped, no effect on `sym_data` or `sym_len`. A symbol made only of glitches produces no strobe.
- Eight long pulses separated by gaps of 5: `sym_len`=7, `sym_data`=7'b1111111, `sym_ovf`=1. The next symbol reports `sym_ovf`=0.
- Gap of exactly 19 cycles between pulses: the symbol stays open. Gap of 20: the symbol closes. Check the rise that coincides with emit is ignored, as stated in the timing rules.
- `rst_n` asserted during the HIGH of a third pulse: outputs return to 0 immediately. After release, a single 12-cycle pulse gives `sym_data`=1, `sym_len`=1.
